load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the core execute stage and a byte-enabled, ack-handshaked data bus.
// Handles lane steering, sign/zero extension, misalignment/illegal-size faults and bus timeout.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [2:0]        req_f3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [XLEN-1:0]   req_wdata_i,
   input  logic [4:0]        req_rd_i,
   output logic              rsp_valid_o,
   output logic [4:0]        rsp_rd_o,
   output logic [XLEN-1:0]   rsp_data_o,
   output logic              rsp_fault_o,
   output logic [1:0]        rsp_cause_o,
   output logic [ADDR_W-1:0] rsp_addr_o,
   output logic              mem_req_o,
   output logic              mem_wr_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [XLEN-1:0]   mem_rdata_i
);

   localparam int NB = XLEN / 8;
   localparam int OB = $clog2(NB);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [4:0]        rd_q, rd_d;

   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [4:0]        rsp_rd_q, rsp_rd_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic [1:0]        rsp_cause_q, rsp_cause_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [NB-1:0]     mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

   // Request decode, straight from the request inputs
   logic [OB-1:0]   in_off;
   logic [3:0]      in_bytes;
   logic [OB-1:0]   in_size_mask;
   logic            in_illegal;
   logic            in_mis;
   logic [NB-1:0]   in_be;
   logic [XLEN-1:0] in_wdata_sh;
   logic [XLEN-1:0] in_wdata;

   always_comb begin
      in_off       = req_addr_i[OB-1:0];
      in_bytes     = 4'd1 << req_f3_i[1:0];
      in_size_mask = OB'(in_bytes - 4'd1);
      in_illegal   = (req_f3_i == 3'b111) || (req_we_i && req_f3_i[2]) ||
                     ((XLEN == 32) && ((req_f3_i[1:0] == 2'b11) || (req_f3_i == 3'b110)));
      in_mis       = (in_off & in_size_mask) != '0;
      in_wdata_sh  = req_wdata_i << {in_off, 3'b000};
      in_be        = '0;
      in_wdata     = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         in_be[i] = (i >= 32'(in_off)) && (i < 32'(in_off) + 32'(in_bytes));
         in_wdata[8*i +: 8] = in_be[i] ? in_wdata_sh[8*i +: 8] : 8'h00;
      end
   end

   // Load data extraction from the captured request
   logic [XLEN-1:0] ld_sh;
   logic [XLEN-1:0] ld_data;
   logic [31:0]     ld_bits;
   logic            ld_sign;

   always_comb begin
      ld_sh   = mem_rdata_i >> {addr_q[OB-1:0], 3'b000};
      ld_bits = 32'd8 << f3_q[1:0];
      case (f3_q[1:0])
         2'd0:    ld_sign = ld_sh[7];
         2'd1:    ld_sign = ld_sh[15];
         2'd2:    ld_sign = ld_sh[31];
         default: ld_sign = ld_sh[XLEN-1];
      endcase
      ld_data = '0;
      for (int unsigned b = 0; b < XLEN; b++) begin
         ld_data[b] = (b < ld_bits) ? ld_sh[b] : (ld_sign & ~f3_q[2]);
      end
   end

   logic accept;
   assign accept = req_valid_i && ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      rd_d        = rd_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_rd_d    = '0;
      rsp_data_d  = '0;
      rsp_fault_d = 1'b0;
      rsp_cause_d = 2'd0;
      rsp_addr_d  = '0;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE, RESP: begin
            // RESP also accepts, giving back-to-back throughput
            ready_d = 1'b1;
            state_d = IDLE;
            if (accept) begin
               we_d   = req_we_i;
               f3_d   = req_f3_i;
               addr_d = req_addr_i;
               rd_d   = req_rd_i;
               if (in_illegal || in_mis) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_fault_d = 1'b1;
                  rsp_cause_d = in_illegal ? 2'd3 : 2'd1;
                  rsp_addr_d  = req_addr_i;
               end else begin
                  state_d     = BUS;
                  ready_d     = 1'b0;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_wr_d    = req_we_i;
                  mem_addr_d  = {req_addr_i[ADDR_W-1:OB], {OB{1'b0}}};
                  mem_be_d    = in_be;
                  mem_wdata_d = in_wdata;
               end
            end
         end
         BUS: begin
            if (mem_ack_i || ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1)))) begin
               state_d     = RESP;
               ready_d     = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_addr_d  = addr_q;
               mem_req_d   = 1'b0;
               mem_wr_d    = 1'b0;
               mem_addr_d  = '0;
               mem_be_d    = '0;
               mem_wdata_d = '0;
               if (mem_ack_i) begin
                  rsp_rd_d   = we_q ? 5'd0 : rd_q;
                  rsp_data_d = we_q ? '0 : ld_data;
               end else begin
                  rsp_fault_d = 1'b1;
                  rsp_cause_d = 2'd2;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         f3_q        <= '0;
         addr_q      <= '0;
         rd_q        <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= '0;
         rsp_data_q  <= '0;
         rsp_fault_q <= 1'b0;
         rsp_cause_q <= '0;
         rsp_addr_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         rd_q        <= rd_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_data_q  <= rsp_data_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_cause_q <= rsp_cause_d;
         rsp_addr_q  <= rsp_addr_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rd_o    = rsp_rd_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_fault_o = rsp_fault_q;
   assign rsp_cause_o = rsp_cause_q;
   assign rsp_addr_o  = rsp_addr_q;
   assign mem_req_o   = mem_req_q;
   assign mem_wr_o    = mem_wr_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: an XLEN=32 and an XLEN=64 instance (TIMEOUT=4) behind a select mux.
// Directed table vectors, a mid-transaction reset sequence and randomized requests against a model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_f3 = '0;
   logic [31:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_ack = 1'b0;
   logic [63:0] mem_rdata = '0;

   always #5 clk = ~clk;

   logic        r32, v32, f32, q32, w32;
   logic [4:0]  rd32;
   logic [31:0] d32, a32, ma32, wd32;
   logic [1:0]  c32;
   logic [3:0]  be32;
   logic        r64, v64, f64, q64, w64;
   logic [4:0]  rd64;
   logic [63:0] d64, wd64;
   logic [31:0] a64, ma64;
   logic [1:0]  c64;
   logic [7:0]  be64;

   load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid & ~sel), .req_ready_o(r32), .req_we_i(req_we), .req_f3_i(req_f3),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata[31:0]), .req_rd_i(req_rd),
      .rsp_valid_o(v32), .rsp_rd_o(rd32), .rsp_data_o(d32), .rsp_fault_o(f32),
      .rsp_cause_o(c32), .rsp_addr_o(a32),
      .mem_req_o(q32), .mem_wr_o(w32), .mem_addr_o(ma32), .mem_be_o(be32), .mem_wdata_o(wd32),
      .mem_ack_i(mem_ack & ~sel), .mem_rdata_i(mem_rdata[31:0]));

   load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid & sel), .req_ready_o(r64), .req_we_i(req_we), .req_f3_i(req_f3),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
      .rsp_valid_o(v64), .rsp_rd_o(rd64), .rsp_data_o(d64), .rsp_fault_o(f64),
      .rsp_cause_o(c64), .rsp_addr_o(a64),
      .mem_req_o(q64), .mem_wr_o(w64), .mem_addr_o(ma64), .mem_be_o(be64), .mem_wdata_o(wd64),
      .mem_ack_i(mem_ack & sel), .mem_rdata_i(mem_rdata));

   wire        o_ready = sel ? r64 : r32;
   wire        o_rsp_v = sel ? v64 : v32;
   wire [4:0]  o_rd    = sel ? rd64 : rd32;
   wire [63:0] o_data  = sel ? d64 : {32'h0, d32};
   wire        o_fault = sel ? f64 : f32;
   wire [1:0]  o_cause = sel ? c64 : c32;
   wire [31:0] o_raddr = sel ? a64 : a32;
   wire        o_req   = sel ? q64 : q32;
   wire        o_wr    = sel ? w64 : w32;
   wire [31:0] o_maddr = sel ? ma64 : ma32;
   wire [7:0]  o_be    = sel ? be64 : {4'h0, be32};
   wire [63:0] o_wdata = sel ? wd64 : {32'h0, wd32};

   typedef struct {
      bit          fault;
      logic [1:0]  cause;
      int          reqcyc;
      logic [7:0]  be;
      logic [31:0] maddr;
      logic [63:0] mwdata;
      bit          wr;
      logic [63:0] data;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      int          lat;
      int          reqcyc;
      logic [7:0]  be;
      logic [31:0] maddr;
      logic [63:0] mwdata;
      logic        wr;
      bit          stable;
      logic        ready_after_accept;
      logic        fault;
      logic [1:0]  cause;
      logic [63:0] data;
      logic [4:0]  rd;
      logic [31:0] raddr;
      logic        ready_at_rsp;
      logic        req_at_rsp;
      logic        pulse_ok;
   } obs_t;

   typedef struct {
      bit          x64;
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [63:0] wd;
      logic [63:0] rdat;
      int          ack;
      exp_t        e;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total_cnt++;
      if (got !== want) $display("FAIL %s: got %h expected %h", nm, got, want);
      else pass_cnt++;
   endtask

   function automatic vec_t row(bit x64, bit we, logic [2:0] f3, logic [31:0] addr,
                                logic [63:0] wd, logic [63:0] rdat, int ack,
                                logic [7:0] be, logic [31:0] maddr, logic [63:0] mwd,
                                logic [63:0] data, bit fault, logic [1:0] cause, int rc);
      vec_t v;
      v.x64 = x64; v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdat = rdat; v.ack = ack;
      v.e.fault = fault; v.e.cause = cause; v.e.reqcyc = rc; v.e.be = be; v.e.maddr = maddr;
      v.e.mwdata = mwd; v.e.wr = we; v.e.data = data;
      v.e.rd = (we || fault) ? 5'd0 : 5'd7;
      return v;
   endfunction

   // Reference model: arithmetic on byte counts and offsets, TIMEOUT fixed at 4
   function automatic exp_t model(bit x64, bit we, logic [2:0] f3, logic [31:0] addr,
                                  logic [63:0] wd, logic [63:0] rdat, int ack, logic [4:0] rd);
      exp_t e;
      int nb = x64 ? 8 : 4;
      int bytes = 1 << f3[1:0];
      int off = int'(addr[2:0]) % nb;
      bit illegal = (f3 == 3'b111) || (we && f3[2]) || (!x64 && (bytes == 8 || f3 == 3'b110));
      bit mis = (off % bytes) != 0;
      logic [127:0] lanes, v, rfull;
      e = '{default: 0};
      e.wr = we;
      if (illegal || mis) begin
         e.fault = 1; e.cause = illegal ? 2'd3 : 2'd1;
         return e;
      end
      e.be = 8'(((1 << bytes) - 1) << off);
      lanes = 128'(wd) & ((128'd1 << (8 * bytes)) - 1);
      e.mwdata = 64'(lanes << (8 * off));
      e.maddr = addr - 32'(off);
      if (ack == 0 || ack > 4) begin
         e.fault = 1; e.cause = 2'd2; e.reqcyc = 4;
         return e;
      end
      e.reqcyc = ack;
      if (!we) begin
         rfull = x64 ? 128'(rdat) : 128'(rdat[31:0]);
         v = (rfull >> (8 * off)) & ((128'd1 << (8 * bytes)) - 1);
         if (!f3[2] && v >= (128'd1 << (8 * bytes - 1)))
            v = v + ((128'd1 << (8 * nb)) - (128'd1 << (8 * bytes)));
         e.data = 64'(v);
         e.rd = rd;
      end
      return e;
   endfunction

   // Starts and ends just after a falling edge
   task automatic run(input bit x64, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [63:0] rdat, input int ack,
                      input logic [4:0] rd, output obs_t o);
      o = '{default: 0};
      o.stable = 1;
      sel = x64;
      req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      o.ready_after_accept = o_ready;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (o_rsp_v) begin
            o.lat = c; o.fault = o_fault; o.cause = o_cause; o.data = o_data; o.rd = o_rd;
            o.raddr = o_raddr; o.ready_at_rsp = o_ready; o.req_at_rsp = o_req;
            break;
         end
         if (o_req) begin
            o.reqcyc++;
            if (o.reqcyc == 1) begin
               o.be = o_be; o.maddr = o_maddr; o.mwdata = o_wdata; o.wr = o_wr;
            end else if (o.be !== o_be || o.maddr !== o_maddr || o.mwdata !== o_wdata || o.wr !== o_wr) begin
               o.stable = 0;
            end
            mem_ack = (o.reqcyc == ack);
            mem_rdata = rdat;
         end else begin
            mem_ack = 1'b0;
         end
      end
      mem_ack = 1'b0;
      @(negedge clk);
      o.pulse_ok = !o_rsp_v && o_ready;
   endtask

   task automatic verify(input string nm, input obs_t o, input exp_t e, input logic [31:0] addr);
      chk({nm, " latency"}, 64'(o.lat), 64'((e.reqcyc == 0) ? 1 : e.reqcyc + 1));
      chk({nm, " req_cycles"}, 64'(o.reqcyc), 64'(e.reqcyc));
      if (e.reqcyc > 0) begin
         chk({nm, " be"}, 64'(o.be), 64'(e.be));
         chk({nm, " mem_addr"}, 64'(o.maddr), 64'(e.maddr));
         chk({nm, " mem_wdata"}, o.mwdata, e.mwdata);
         chk({nm, " mem_wr"}, 64'(o.wr), 64'(e.wr));
         chk({nm, " bus_stable"}, 64'(o.stable), 64'd1);
         chk({nm, " ready_after_accept"}, 64'(o.ready_after_accept), 64'd0);
      end
      chk({nm, " fault"}, 64'(o.fault), 64'(e.fault));
      chk({nm, " cause"}, 64'(o.cause), 64'(e.cause));
      chk({nm, " rsp_data"}, o.data, e.data);
      chk({nm, " rsp_rd"}, 64'(o.rd), 64'(e.rd));
      chk({nm, " rsp_addr"}, 64'(o.raddr), 64'(addr));
      chk({nm, " ready_at_rsp"}, 64'(o.ready_at_rsp), 64'd1);
      chk({nm, " req_low_at_rsp"}, 64'(o.req_at_rsp), 64'd0);
      chk({nm, " rsp_pulse"}, 64'(o.pulse_ok), 64'd1);
   endtask

   vec_t tbl[17];
   obs_t ob;
   exp_t ex;

   initial begin
      tbl[0]  = row(0, 1, 3'd0, 32'h1003, 64'hAABBCCDD, 0, 1, 8'h08, 32'h1000, 64'hDD000000, 0, 0, 0, 1);
      tbl[1]  = row(0, 0, 3'd1, 32'h2002, 0, 64'h80011234, 1, 8'h0C, 32'h2000, 0, 64'hFFFF8001, 0, 0, 1);
      tbl[2]  = row(0, 0, 3'd5, 32'h2002, 0, 64'h80011234, 1, 8'h0C, 32'h2000, 0, 64'h00008001, 0, 0, 1);
      tbl[3]  = row(0, 0, 3'd0, 32'h2000, 0, 64'h80011234, 1, 8'h01, 32'h2000, 0, 64'h34, 0, 0, 1);
      tbl[4]  = row(0, 0, 3'd2, 32'h2002, 0, 64'h80011234, 1, 0, 0, 0, 0, 1, 1, 0);
      tbl[5]  = row(0, 0, 3'd2, 32'h2000, 0, 64'h80011234, 0, 8'h0F, 32'h2000, 0, 0, 1, 2, 4);
      tbl[6]  = row(0, 0, 3'd2, 32'h2000, 0, 64'h80011234, 4, 8'h0F, 32'h2000, 0, 64'h80011234, 0, 0, 4);
      tbl[7]  = row(1, 0, 3'd3, 32'h10, 0, 64'h8000000000000001, 2, 8'hFF, 32'h10, 0, 64'h8000000000000001, 0, 0, 2);
      tbl[8]  = row(1, 0, 3'd6, 32'h14, 0, 64'hF000000012345678, 1, 8'hF0, 32'h10, 0, 64'h00000000F0000000, 0, 0, 1);
      tbl[9]  = row(1, 1, 3'd3, 32'h18, 64'h1122334455667788, 0, 1, 8'hFF, 32'h18, 64'h1122334455667788, 0, 0, 0, 1);
      tbl[10] = row(0, 0, 3'd3, 32'h2000, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0);
      tbl[11] = row(0, 1, 3'd4, 32'h2000, 64'h55, 0, 1, 0, 0, 0, 0, 1, 3, 0);
      tbl[12] = row(1, 0, 3'd2, 32'h14, 0, 64'h8000000000000000, 1, 8'hF0, 32'h10, 0, 64'hFFFFFFFF80000000, 0, 0, 1);
      tbl[13] = row(1, 1, 3'd1, 32'h13, 64'h1234, 0, 1, 0, 0, 0, 0, 1, 1, 0);
      tbl[14] = row(0, 0, 3'd6, 32'h2001, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0);
      tbl[15] = row(0, 1, 3'd1, 32'h2002, 64'hBEEF, 0, 3, 8'h0C, 32'h2000, 64'hBEEF0000, 0, 0, 0, 3);
      tbl[16] = row(1, 1, 3'd0, 32'h25, 64'hAB, 0, 1, 8'h20, 32'h20, 64'h0000AB0000000000, 0, 0, 0, 1);

      // Reset state of both instances, then ready one edge after release
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         chk("reset ready", 64'(o_ready), 0);
         chk("reset mem_req", 64'(o_req), 0);
         chk("reset rsp_valid", 64'(o_rsp_v), 0);
         chk("reset be", 64'(o_be), 0);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 chk("ready before first edge", 64'(o_ready), 0);
      @(negedge clk);
      chk("ready after release", 64'(o_ready), 1);

      foreach (tbl[i]) begin
         run(tbl[i].x64, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdat, tbl[i].ack, 5'd7, ob);
         verify($sformatf("vec%0d", i), ob, tbl[i].e, tbl[i].addr);
      end

      // Reset two cycles into BUS discards the request
      sel = 1'b0;
      req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h40; req_wdata = 64'h12345678; req_rd = 5'd3;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-reset mem_req", 64'(o_req), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset mem_req", 64'(o_req), 0);
      chk("midreset ready", 64'(o_ready), 0);
      chk("midreset be", 64'(o_be), 0);
      chk("midreset wdata", o_wdata, 0);
      chk("midreset addr", 64'(o_maddr), 0);
      chk("midreset wr", 64'(o_wr), 0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("midreset no rsp", 64'(o_rsp_v), 0);
      end
      rst_n = 1'b1;
      #1 chk("ready held after release", 64'(o_ready), 0);
      @(negedge clk);
      chk("ready one edge after release", 64'(o_ready), 1);
      chk("no stale rsp", 64'(o_rsp_v), 0);
      run(0, 1, 3'd2, 32'h44, 64'hCAFEF00D, 0, 2, 5'd3, ob);
      verify("sw after reset", ob, model(0, 1, 3'd2, 32'h44, 64'hCAFEF00D, 0, 2, 5'd3), 32'h44);

      // Randomized requests against the model
      for (int n = 0; n < 150; n++) begin
         bit x64, we;
         logic [2:0] f3;
         logic [31:0] addr;
         logic [63:0] wd, rdat;
         logic [4:0] rd;
         int ack;
         x64 = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         addr = 32'h3000_0000 | 32'($urandom_range(0, 255));
         wd = {$urandom, $urandom};
         rdat = {$urandom, $urandom};
         rd = 5'($urandom_range(1, 31));
         ack = $urandom_range(0, 6);
         ex = model(x64, we, f3, addr, wd, rdat, ack, rd);
         run(x64, we, f3, addr, wd, rdat, ack, rd, ob);
         verify($sformatf("rand%0d", n), ob, ex, addr);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
